// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: multi-channel periodic interrupt scheduler with round-robin irq/ack arbitration
module timer_irq_ctrl #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             cfg_we_i,
  input  logic [IDW-1:0]   cfg_ch_i,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic             cfg_enable_i,
  input  logic             ack_i,
  output logic             irq_o,
  output logic [IDW-1:0]   irq_id_o,
  output logic [NCH-1:0]   pending_o,
  output logic [NCH-1:0]   overrun_o
);
  typedef enum logic {IDLE, SERVE} state_t;
  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, sel, idx;
  logic [NCH-1:0]   en_q, en_d, pend_q, pend_d, ovr_q, ovr_d, hit, clr, fire;
  logic [WIDTH-1:0] period_q [NCH];
  logic [WIDTH-1:0] period_d [NCH];
  logic [WIDTH-1:0] cnt_q [NCH];
  logic [WIDTH-1:0] cnt_d [NCH];
  // a config write overrides tick and ack on its channel; a fire beats a same-cycle ack
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      hit[i]      = cfg_we_i && cfg_ch_i == IDW'(i);
      clr[i]      = state_q == SERVE && ack_i && id_q == IDW'(i);
      fire[i]     = tick_i && en_q[i] && cnt_q[i] == '0;
      en_d[i]     = hit[i] ? cfg_enable_i : en_q[i];
      period_d[i] = hit[i] ? cfg_period_i : period_q[i];
      cnt_d[i]    = hit[i] ? cfg_period_i :
                    !(tick_i && en_q[i]) ? cnt_q[i] :
                    fire[i] ? period_q[i] : cnt_q[i] - WIDTH'(1);
      pend_d[i]   = !hit[i] && (fire[i] || (pend_q[i] && !clr[i]));
      ovr_d[i]    = !hit[i] && (ovr_q[i] || (fire[i] && pend_q[i] && !clr[i]));
    end
  end
  // scan downward so the pending channel closest to ptr wins
  always_comb begin
    sel = ptr_q;
    idx = ptr_q;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = ptr_q + IDW'(k);
      sel = pend_q[idx] ? idx : sel;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    if (state_q == IDLE && |pend_q) begin
      state_d = SERVE;
      id_d    = sel;
    end else if (state_q == SERVE && ack_i) begin
      state_d = IDLE;
      ptr_d   = id_q + IDW'(1);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      en_q     <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      period_q <= '{default: '0};
      cnt_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end
  assign irq_o     = state_q == SERVE;
  assign irq_id_o  = id_q;
  assign pending_o = pend_q;
  assign overrun_o = ovr_q;
endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Programmable interrupt scheduler that sits on top of the free-running 8-bit `timer` tick. It shares one tick source among NCH software-configured channels. Each channel has its own reload period and enable. When a channel's period expires, the block raises a pending request. A round-robin arbiter presents one request at a time to the processor core over an irq/ack handshake. Lost events are flagged per channel as sticky overruns.

## Interface
- NCH, 4, number of timer channels (power of two, 2..8)
- WIDTH, 8, width of period registers and channel down-counters
- IDW, 2, width of channel index; must equal log2(NCH)
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- tick  in  1  single-cycle pulse from the `timer` block's `salida` output
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  IDW  channel targeted by the configuration write
- cfg_period  in  WIDTH  reload value; channel fires every cfg_period+1 ticks
- cfg_enable  in  1  channel enable written with the period
- ack  in  1  core acknowledges the request currently presented
- irq  out  1  interrupt request to core, registered
- irq_id  out  IDW  channel being presented, valid while irq=1, registered
- pending  out  NCH  per-channel pending flags
- overrun  out  NCH  sticky per-channel overrun flags

## Operation
- Per-channel state: en, period[WIDTH], cnt[WIDTH], pend, ovr. Global state: FSM (IDLE/SERVE), rr pointer ptr[IDW], latched id.
- Channel on a tick with en=1:
  - cnt==0: reload cnt<=period and fire.
  - cnt!=0: cnt<=cnt-1 (no wrap; 0 only ever reloads).
- Channels with en=0 ignore tick and hold cnt.
- Fire: pend<=1. If pend was already 1 and is not being cleared by ack this cycle, ovr<=1 as well.
- Config write (cfg_we=1) to channel c:
  - period<=cfg_period, cnt<=cfg_period, en<=cfg_enable, pend<=0, ovr<=0.
  - Config write has priority over a same-cycle tick on channel c. Other channels process the tick normally.
- FSM:
  - IDLE: if any pend=1, pick the first pending channel scanning ptr, ptr+1, ... mod NCH. Latch it into id, go to SERVE.
  - SERVE: irq=1, irq_id=id held stable. On ack: pend[id]<=0, ptr<=id+1 mod NCH, go to IDLE.
  - ack in IDLE is ignored.
- Simultaneous fire and ack on the served channel: the new fire wins. pend stays 1, no overrun.
- Config write to the served channel while in SERVE: pend is cleared, but SERVE still waits for ack. The ack is then harmless.
- Period 0 on an enabled channel fires on every tick.

## Timing
- Reset values: irq=0, irq_id=0, pending=0, overrun=0, all en/period/cnt=0, FSM=IDLE, ptr=0.
- tick sampled at edge N → pend visible after edge N.
- IDLE with pending at edge N+1 → irq=1 and irq_id valid after edge N+1. Tick-to-irq latency is 2 cycles.
- ack sampled at edge M → irq=0 and pend cleared after edge M.
- Next irq can assert at the earliest after edge M+1, which guarantees at least one cycle of irq=0 between requests.
- irq_id never changes while irq=1.
- Reset asserted mid-SERVE drops irq asynchronously and discards all pending and config state.

## Test plan
- Reset, then write ch0 period=3 en=1, pulse tick every 4 cycles → irq rises 2 cycles after every 4th tick with irq_id=0. ack clears pending[0]. overrun stays 0.
- Enable ch1 and ch2, both period=0, one tick, no ack, ptr=0 → irq_id=1. After ack, irq_id=2 appears 2 cycles later. After ack, ptr=3 and irq=0.
- ch0 period=0, 2 ticks without ack → pending[0]=1, overrun[0]=1. Config write to ch0 → pending[0]=0, overrun[0]=0.
- ch3 period=0 in SERVE on ch3, with tick and ack in the same cycle → pending[3] stays 1, overrun[3]=0. irq reasserts with id=3 after 1 idle cycle.
- Config write to ch0 (period=5) in the same cycle as a tick → cnt0=5 afterwards and no fire. With en=0, 10 ticks produce no irq.
- Assert reset asynchronously while irq=1 → irq, pending and overrun go to 0 before the next clock edge. Ticks after reset produce no irq until reconfigured.
